// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access stage and its MEM/WB register.
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_ALU = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_PC  = 2'd2;
  localparam logic [1:0] SEL_IMM = 2'd3;

  // A bubble must never write the register file; all data fields are zero.
  localparam logic        BUBBLE_WRITE = 1'b0;
  localparam logic [1:0]  BUBBLE_SEL   = SEL_ALU;
  localparam logic [31:0] BUBBLE_WORD  = 32'h0000_0000;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register with a bubble-insert input that overrides the data path.
module mem_wb_reg
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        bubble,
  input  logic        reg_file_write_d,
  input  logic [1:0]  select_mux_4_d,
  input  logic [31:0] alu_d,
  input  logic [31:0] mem_data_d,
  input  logic [31:0] add_pc_d,
  output logic        reg_file_write_q,
  output logic [1:0]  select_mux_4_q,
  output logic [31:0] alu_q,
  output logic [31:0] mem_data_q,
  output logic [31:0] add_pc_q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_file_write_q <= 1'b0;
      select_mux_4_q   <= 2'd0;
      alu_q            <= 32'h0;
      mem_data_q       <= 32'h0;
      add_pc_q         <= 32'h0;
    end else if (bubble) begin
      reg_file_write_q <= BUBBLE_WRITE;
      select_mux_4_q   <= BUBBLE_SEL;
      alu_q            <= BUBBLE_WORD;
      mem_data_q       <= BUBBLE_WORD;
      add_pc_q         <= BUBBLE_WORD;
    end else begin
      reg_file_write_q <= reg_file_write_d;
      select_mux_4_q   <= select_mux_4_d;
      alu_q            <= alu_d;
      mem_data_q       <= mem_data_d;
      add_pc_q         <= add_pc_d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: drives the data-memory handshake, stalls upstream while an
// access is outstanding, and feeds the MEM/WB register.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re_in,
  input  logic        mem_we_in,
  input  logic        reg_file_write_in,
  input  logic [1:0]  select_mux_4_in,
  input  logic [31:0] reg_b_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] add_pc_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output logic        reg_file_write_out,
  output logic [1:0]  select_mux_4_out,
  output logic [31:0] alu_out,
  output logic [31:0] mem_data_out,
  output logic [31:0] add_pc_out,
  output logic        misaligned_out,
  output logic        bus_err_out
);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;

  logic        lat_we, lat_rfw;
  logic [1:0]  lat_sel;
  logic [31:0] lat_addr, lat_wdata, lat_add_pc;

  logic access, aligned;
  logic latch_en, set_misaligned, set_bus_err;
  logic req_c, we_c, stall_c;
  logic [31:0] addr_c, wdata_c;

  logic        wb_bubble, wb_rfw;
  logic [1:0]  wb_sel;
  logic [31:0] wb_alu, wb_mem_data, wb_add_pc;

  assign access  = mem_re_in | mem_we_in;
  assign aligned = (alu_in[1:0] == 2'b00);

  always_comb begin
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    latch_en       = 1'b0;
    set_misaligned = 1'b0;
    set_bus_err    = 1'b0;
    req_c          = 1'b0;
    we_c           = 1'b0;
    addr_c         = 32'h0;
    wdata_c        = 32'h0;
    stall_c        = 1'b0;
    wb_bubble      = 1'b0;
    wb_rfw         = reg_file_write_in;
    wb_sel         = select_mux_4_in;
    wb_alu         = alu_in;
    wb_mem_data    = BUBBLE_WORD;
    wb_add_pc      = add_pc_in;

    case (state)
      IDLE: begin
        if (access && !aligned) begin
          set_misaligned = 1'b1;
          wb_bubble      = 1'b1;
        end else if (access) begin
          req_c   = 1'b1;
          we_c    = mem_we_in;
          addr_c  = alu_in;
          wdata_c = reg_b_in;
          if (dmem_ready) begin
            wb_rfw      = reg_file_write_in & ~mem_we_in;
            wb_mem_data = mem_we_in ? BUBBLE_WORD : dmem_rdata;
          end else begin
            latch_en      = 1'b1;
            wait_cnt_next = CNT_W'(1);
            state_next    = WAIT;
            stall_c       = 1'b1;
            wb_bubble     = 1'b1;
          end
        end
      end

      // Inputs are frozen upstream, so everything comes from the latched copies.
      WAIT: begin
        req_c     = 1'b1;
        we_c      = lat_we;
        addr_c    = lat_addr;
        wdata_c   = lat_wdata;
        wb_rfw    = lat_rfw & ~lat_we;
        wb_sel    = lat_sel;
        wb_alu    = lat_addr;
        wb_add_pc = lat_add_pc;
        if (dmem_ready) begin
          wb_mem_data   = lat_we ? BUBBLE_WORD : dmem_rdata;
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
          set_bus_err   = 1'b1;
          wb_bubble     = 1'b1;
          state_next    = IDLE;
          wait_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
          stall_c       = 1'b1;
          wb_bubble     = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we     <= 1'b0;
      lat_rfw    <= 1'b0;
      lat_sel    <= 2'd0;
      lat_addr   <= 32'h0;
      lat_wdata  <= 32'h0;
      lat_add_pc <= 32'h0;
    end else if (latch_en) begin
      lat_we     <= mem_we_in;
      lat_rfw    <= reg_file_write_in;
      lat_sel    <= select_mux_4_in;
      lat_addr   <= alu_in;
      lat_wdata  <= reg_b_in;
      lat_add_pc <= add_pc_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misaligned_out <= 1'b0;
      bus_err_out    <= 1'b0;
    end else begin
      if (set_misaligned) misaligned_out <= 1'b1;
      if (set_bus_err)    bus_err_out    <= 1'b1;
    end
  end

  // Gating with reset withdraws a pending request the instant reset asserts.
  assign dmem_req   = reset & req_c;
  assign dmem_we    = reset & we_c;
  assign dmem_addr  = reset ? addr_c  : 32'h0;
  assign dmem_wdata = reset ? wdata_c : 32'h0;
  assign stall_out  = reset & stall_c;

  mem_wb_reg u_mem_wb_reg (
    .clk              (clk),
    .reset            (reset),
    .bubble           (wb_bubble),
    .reg_file_write_d (wb_rfw),
    .select_mux_4_d   (wb_sel),
    .alu_d            (wb_alu),
    .mem_data_d       (wb_mem_data),
    .add_pc_d         (wb_add_pc),
    .reg_file_write_q (reg_file_write_out),
    .select_mux_4_q   (select_mux_4_out),
    .alu_q            (alu_out),
    .mem_data_q       (mem_data_out),
    .add_pc_q         (add_pc_out)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Transaction-level bench for mem_access_stage: each access is described by its kind,
// operands and memory wait count, and the expected stall and write-back are derived from that.
module tb_mem_access_stage;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re_in, mem_we_in, reg_file_write_in;
  logic [1:0]  select_mux_4_in;
  logic [31:0] reg_b_in, alu_in, add_pc_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_out, reg_file_write_out;
  logic [1:0]  select_mux_4_out;
  logic [31:0] alu_out, mem_data_out, add_pc_out;
  logic        misaligned_out, bus_err_out;

  int n_compared   = 0;
  int n_mismatched = 0;
  logic exp_mis = 1'b0;
  logic exp_bus = 1'b0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk                (clk),
    .reset              (reset),
    .mem_re_in          (mem_re_in),
    .mem_we_in          (mem_we_in),
    .reg_file_write_in  (reg_file_write_in),
    .select_mux_4_in    (select_mux_4_in),
    .reg_b_in           (reg_b_in),
    .alu_in             (alu_in),
    .add_pc_in          (add_pc_in),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ready         (dmem_ready),
    .dmem_rdata         (dmem_rdata),
    .stall_out          (stall_out),
    .reg_file_write_out (reg_file_write_out),
    .select_mux_4_out   (select_mux_4_out),
    .alu_out            (alu_out),
    .mem_data_out       (mem_data_out),
    .add_pc_out         (add_pc_out),
    .misaligned_out     (misaligned_out),
    .bus_err_out        (bus_err_out)
  );

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic check_wb(input string tag, input logic rfw, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] mdata, input logic [31:0] pc);
    check_output({tag, ".rfw"},   reg_file_write_out, rfw);
    check_output({tag, ".sel"},   select_mux_4_out, sel);
    check_output({tag, ".alu"},   alu_out, alu);
    check_output({tag, ".mdata"}, mem_data_out, mdata);
    check_output({tag, ".pc"},    add_pc_out, pc);
    check_output({tag, ".mis"},   misaligned_out, exp_mis);
    check_output({tag, ".buserr"}, bus_err_out, exp_bus);
  endtask

  task automatic scramble_inputs();
    mem_re_in         = 1'($urandom);
    mem_we_in         = 1'($urandom);
    reg_file_write_in = 1'($urandom);
    select_mux_4_in   = 2'($urandom);
    reg_b_in          = $urandom;
    alu_in            = $urandom;
    add_pc_in         = $urandom;
    dmem_rdata        = $urandom;
  endtask

  // kind: 0 bubble, 1 load, 2 store, 3 load+store (acts as store); k = memory wait cycles.
  // Called just after a rising edge; returns just after the edge that registers the result.
  task automatic apply_stimulus(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] pc, input logic [31:0] rdata, input logic rfw,
                                input logic [1:0] sel, input int k);
    logic is_access, is_store, mis, req;
    int stalls;
    bit exp_stall;
    is_access = (kind != 0);
    is_store  = (kind >= 2);
    mis       = is_access && (addr[1:0] != 2'b00);
    req       = is_access && !mis;
    mem_re_in         = (kind == 1) || (kind == 3);
    mem_we_in         = is_store;
    reg_file_write_in = rfw;
    select_mux_4_in   = sel;
    reg_b_in          = wdata;
    alu_in            = addr;
    add_pc_in         = pc;
    dmem_rdata        = rdata;
    dmem_ready        = req ? (k == 0) : 1'($urandom);

    @(negedge clk);
    check_output("req", dmem_req, req);
    check_output("stall0", stall_out, req && (k != 0));
    if (req) begin
      check_output("addr", dmem_addr, addr);
      check_output("wdata", dmem_wdata, wdata);
      check_output("we", dmem_we, is_store);
    end

    if (!req) begin
      @(posedge clk); #1;
      if (mis) begin
        exp_mis = 1'b1;
        check_wb("misaligned", 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
      end else begin
        check_wb("passthru", rfw, sel, addr, 32'h0, pc);
      end
    end else if (k == 0) begin
      @(posedge clk); #1;
      check_wb("zerowait", rfw && !is_store, sel, addr, is_store ? 32'h0 : rdata, pc);
    end else begin
      stalls = 1;
      for (int j = 1; j <= TIMEOUT; j++) begin
        @(posedge clk); #1;
        check_output("stallbubble.rfw", reg_file_write_out, 1'b0);
        check_output("stallbubble.alu", alu_out, 32'h0);
        scramble_inputs();
        dmem_ready = (j == k);
        if (j == k) dmem_rdata = rdata;
        exp_stall = (j != k) && (j < TIMEOUT);
        @(negedge clk);
        check_output("wait.req", dmem_req, 1'b1);
        check_output("wait.addr", dmem_addr, addr);
        check_output("wait.wdata", dmem_wdata, wdata);
        check_output("wait.we", dmem_we, is_store);
        check_output("wait.stall", stall_out, exp_stall);
        if (stall_out) stalls++;
        if (j == k || j == TIMEOUT) break;
      end
      check_output("stallcount", stalls, (k <= TIMEOUT) ? k : TIMEOUT);
      @(posedge clk); #1;
      if (k <= TIMEOUT) begin
        check_wb("waited", rfw && !is_store, sel, addr, is_store ? 32'h0 : rdata, pc);
      end else begin
        exp_bus = 1'b1;
        check_wb("timeout", 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
      end
    end
  endtask

  initial begin
    logic [31:0] raddr;
    int rk;
    reset = 1'b0;
    mem_re_in = 1'b0; mem_we_in = 1'b0; reg_file_write_in = 1'b0; select_mux_4_in = 2'd0;
    reg_b_in = 32'h0; alu_in = 32'h0; add_pc_in = 32'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check_wb("reset", 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    check_output("reset.req", dmem_req, 1'b0);
    check_output("reset.stall", stall_out, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;

    apply_stimulus(1, 32'h100, 32'h0, 32'h404, 32'hDEADBEEF, 1'b1, 2'd1, 0);
    apply_stimulus(2, 32'h204, 32'h12345678, 32'h408, 32'hAAAA5555, 1'b1, 2'd0, 3);
    apply_stimulus(1, 32'h102, 32'h0, 32'h40C, 32'h11111111, 1'b1, 2'd1, 0);
    apply_stimulus(1, 32'h300, 32'h0, 32'h410, 32'h22222222, 1'b1, 2'd1, TIMEOUT + 2);
    apply_stimulus(1, 32'h304, 32'h0, 32'h414, 32'h33333333, 1'b1, 2'd1, 1);
    apply_stimulus(1, 32'h308, 32'h0, 32'h418, 32'h44444444, 1'b1, 2'd1, 0);
    apply_stimulus(3, 32'h30C, 32'h55555555, 32'h41C, 32'h66666666, 1'b1, 2'd0, 0);
    apply_stimulus(0, 32'h12345679, 32'h0, 32'h420, 32'h77777777, 1'b1, 2'd2, 0);
    apply_stimulus(1, 32'h310, 32'h0, 32'h424, 32'h88888888, 1'b1, 2'd1, 0);
    apply_stimulus(1, 32'h314, 32'h0, 32'h428, 32'h99999999, 1'b1, 2'd1, TIMEOUT);

    // Reset during the second wait cycle of a load.
    mem_re_in = 1'b1; mem_we_in = 1'b0; reg_file_write_in = 1'b1; select_mux_4_in = 2'd1;
    alu_in = 32'h500; reg_b_in = 32'h0; add_pc_in = 32'h42C; dmem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b0;
    exp_mis = 1'b0;
    exp_bus = 1'b0;
    #1;
    check_wb("midreset", 1'b0, 2'd0, 32'h0, 32'h0, 32'h0);
    check_output("midreset.req", dmem_req, 1'b0);
    check_output("midreset.addr", dmem_addr, 32'h0);
    check_output("midreset.stall", stall_out, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    apply_stimulus(1, 32'h600, 32'h0, 32'h430, 32'hCAFEF00D, 1'b1, 2'd1, 0);

    for (int n = 0; n < 150; n++) begin
      raddr = $urandom;
      if ($urandom_range(0, 5) != 0) raddr[1:0] = 2'b00;
      rk = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, TIMEOUT + 2));
      apply_stimulus(int'($urandom_range(0, 3)), raddr, $urandom, $urandom, $urandom,
                     1'($urandom), 2'($urandom), rk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
